// File: rtl/bitrev_pair_loader.sv
// Collects an N-sample frame, then presents it as N/2 butterfly operand pairs (mem[2k], mem[2k+1]).
// Define DFT_BITREV_EN to store samples at bit-reversed addresses (decimation-in-time order).
module bitrev_pair_loader #(
  parameter int WORD_SZ = 8,
  parameter int LOG2_N  = 3
) (
  input  logic               i_CLK,
  input  logic               i_RESET,
  input  logic [WORD_SZ-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WORD_SZ-1:0] out1,
  output logic [WORD_SZ-1:0] out2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);
  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;
  localparam logic [LOG2_N-2:0] K_LAST   = '1;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t                      state, state_nxt;
  logic [LOG2_N-1:0]           cnt, waddr;
  logic [LOG2_N-2:0]           k;
  logic [N-1:0][WORD_SZ-1:0]   mem;
  logic                        accept, xfer;

  always_comb begin
    waddr = cnt;
`ifdef DFT_BITREV_EN
    for (int b = 0; b < LOG2_N; b++) waddr[b] = cnt[LOG2_N-1-b];
`endif
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) state <= IDLE;
    else         state <= state_nxt;
  end

  // Handshake outputs decode only the state register.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == CNT_LAST) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && k == K_LAST) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      cnt <= '0;
      k   <= '0;
      mem <= '0;
    end else begin
      if (accept) begin
        mem[waddr] <= in_data;
        cnt        <= cnt + LOG2_N'(1);
        if (cnt == CNT_LAST) k <= '0;
      end
      // k wraps to 0 on the final transfer, ready for the next frame.
      if (xfer) k <= k + (LOG2_N-1)'(1);
    end
  end

  assign out1     = mem[{k, 1'b0}];
  assign out2     = mem[{k, 1'b1}];
  assign out_last = (state == EMIT) && (k == K_LAST);

endmodule
